rgb_gray_stream: RTL and testbench
==================================

Name: rgb_gray_stream

Overview:
- Parametrised, pipelined successor to the single-pixel RGB-to-grayscale converter.
- Accepts one RGB pixel per beat on a valid/ready stream.
- Computes a fixed-point weighted luma with a per-beat selectable coefficient set.
- Emits the gray value replicated on R/G/B output channels, so downstream display/pipeline logic is unchanged.
- Sits between the pixel source (camera/frame reader) and the pixel sink (VGA/frame writer).

Parameters:
- DATA_W, 8, bits per colour channel (legal 4..16).
- COEF_W, 8, fractional bits of coefficients (Q0.COEF_W); every coefficient set sums to 2^COEF_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block can accept input this cycle.
- in_r  input  DATA_W  red.
- in_g  input  DATA_W  green.
- in_b  input  DATA_W  blue.
- in_mode  input  2  coefficient select, sampled with the pixel: 0=BT.601, 1=BT.709, 2=average, 3=passthrough.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  sink accepts output.
- out_r  output  DATA_W  red result.
- out_g  output  DATA_W  green result.
- out_b  output  DATA_W  blue result.

Behaviour:
- Reset: asynchronous, active-low. Clears all stage valid bits. out_valid=0, out_r/out_g/out_b=0. in_ready=1 once rst_n deasserts.
- Reset asserted mid-stream discards all in-flight pixels without emitting them.
- Transfers: a transfer happens when valid and ready are both high on a rising clk edge.
- Producer rules: in_valid must not depend on in_ready. Once out_valid=1, it and out_* hold stable until accepted.
- Pipeline: two register stages, S1 and S2.
  - S1 registers the three products R*cr, G*cg, B*cb (each DATA_W+COEF_W bits) and a passthrough flag.
  - S2 registers the sum, shifted right by COEF_W, and drives out_*.
- Latency: an accepted input appears on out_valid exactly 2 cycles later when out_ready stays high.
- Throughput: one pixel per cycle.
- Stage advance: stage k loads when it is empty or its content is leaving this cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - The ready path is combinational; no bubbles with out_ready=1.
- Backpressure: with out_ready=0 the block holds at most 2 pixels, then in_ready=0. No pixel is lost or duplicated, and order is preserved.
- Coefficients (COEF_W=8; other COEF_W values scale from the package):
  - BT.601: 77/150/29.
  - BT.709: 54/183/19.
  - Average: 85/86/85.
- Sum width: DATA_W+COEF_W+2.
- Result: gray = sum >> COEF_W (truncate). It always fits DATA_W because the coefficients sum to 2^COEF_W; an assertion checks this.
- Output mapping:
  - Gray modes: out_r = out_g = out_b = gray.
  - Mode 3 (passthrough): out_* = in_* unchanged, same 2-cycle latency.
- Mode changes take effect per beat. Pixels already in flight keep the mode they were accepted with.
- Idle: out_* hold their last value while out_valid=0 (no zeroing).

Optional Feature:
- Macro: RGB_GRAY_ROUND_EN.
- Defined: gray = (sum + 2^(COEF_W-1)) >> COEF_W (round half up), saturated to 2^DATA_W-1.
- Undefined: truncation as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package rgb_gray_pkg contains:
  - mode enum: MODE_BT601, MODE_BT709, MODE_AVG, MODE_PASS.
  - per-mode coefficient constants, expressed as functions of COEF_W.
  - a function returning the {cr,cg,cb} triple for a mode.
- One sub-module, rgb_gray_stage: a generic valid/ready pipeline register slice with payload width parameter. It is instantiated twice, for S1 and S2.

Test Plan:
- Reset/idle: hold rst_n=0 while driving inputs → out_valid=0, out_*=0. After release, in_ready=1 with no spurious output.
- BT.601, DATA_W=8:
  - R=255,G=0,B=0 → out 76 on all channels 2 cycles later (77 with RGB_GRAY_ROUND_EN).
  - R=G=B=255 → 255.
- BT.709: G=200, R=B=0 → 142 (143 with rounding).
- Average: R=G=B=90 → 90. Passthrough: (10,20,30) → (10,20,30).
- Backpressure: stream 6 pixels with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepted pixels; out_* stay stable while stalled.
  - After out_ready=1, all 6 emerge in order, back-to-back, with no loss.
- Mid-stream reset and mode switch:
  - Alternate in_mode 0/1 every beat → each output matches its own beat's mode.
  - Assert rst_n=0 with 2 pixels in flight → neither pixel is emitted after release.

Source files
------------

// File: rtl/rgb_gray_pkg.sv
// Shared types and coefficient helpers for the RGB-to-gray stream.
// Coefficients are Q0.coef_w, and each gray set sums to exactly 2^coef_w.
package rgb_gray_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_PASS  = 2'd3
  } mode_t;

  typedef struct packed {
    logic [31:0] cr;
    logic [31:0] cg;
    logic [31:0] cb;
  } coef_t;

  // Rounds num/den into a Q0.coef_w fraction.
  function automatic logic [31:0] scale(longint unsigned num, longint unsigned den,
                                        int unsigned coef_w);
    return 32'(((num << coef_w) + den / 64'd2) / den);
  endfunction

  function automatic logic [31:0] coef_bt601_r(int unsigned coef_w);
    return scale(64'd299, 64'd1000, coef_w);
  endfunction

  function automatic logic [31:0] coef_bt601_g(int unsigned coef_w);
    return scale(64'd587, 64'd1000, coef_w);
  endfunction

  function automatic logic [31:0] coef_bt709_r(int unsigned coef_w);
    return scale(64'd2126, 64'd10000, coef_w);
  endfunction

  function automatic logic [31:0] coef_bt709_g(int unsigned coef_w);
    return scale(64'd7152, 64'd10000, coef_w);
  endfunction

  // Blue absorbs the rounding residue so the set always sums to 2^coef_w.
  function automatic coef_t coef_of(mode_t m, int unsigned coef_w);
    logic [31:0] one;
    coef_t       c;
    one = 32'(64'd1 << coef_w);
    c   = '0;
    case (m)
      MODE_BT601: begin
        c.cr = coef_bt601_r(coef_w);
        c.cg = coef_bt601_g(coef_w);
      end
      MODE_BT709: begin
        c.cr = coef_bt709_r(coef_w);
        c.cg = coef_bt709_g(coef_w);
      end
      MODE_AVG: begin
        c.cr = one / 32'd3;
        c.cg = one - 32'd2 * c.cr;
      end
      default: ;
    endcase
    if (m != MODE_PASS) c.cb = one - c.cr - c.cg;
    return c;
  endfunction

endpackage

// File: rtl/rgb_gray_stage.sv
// Generic valid/ready register slice; loads when empty or when its content leaves.
module rgb_gray_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready_c = !out_valid || out_ready;

  // Payload only changes on a real load, so it holds while idle or stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/rgb_gray_stream.sv
// Two-stage pipelined RGB-to-gray converter on valid/ready streams.
// Define RGB_GRAY_ROUND_EN for round-half-up with saturation instead of truncation.
module rgb_gray_stream
  import rgb_gray_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = DATA_W + COEF_W + 2;
  localparam int unsigned S1_W   = 3 * PROD_W + 1;
  localparam int unsigned S2_W   = 3 * DATA_W;

  localparam coef_t C_BT601 = coef_of(MODE_BT601, COEF_W);
  localparam coef_t C_BT709 = coef_of(MODE_BT709, COEF_W);
  localparam coef_t C_AVG   = coef_of(MODE_AVG, COEF_W);

  mode_t             mode;
  coef_t             coef;
  logic              pass;
  logic [PROD_W-1:0] pr, pg, pb;

  // Passthrough reuses the product fields with raw channels pre-shifted by COEF_W.
  always_comb begin
    mode = mode_t'(in_mode);
    pass = (mode == MODE_PASS);
    coef = '0;
    case (mode)
      MODE_BT601: coef = C_BT601;
      MODE_BT709: coef = C_BT709;
      MODE_AVG:   coef = C_AVG;
      default:    coef = '0;
    endcase
    if (pass) begin
      pr = PROD_W'(in_r) << COEF_W;
      pg = PROD_W'(in_g) << COEF_W;
      pb = PROD_W'(in_b) << COEF_W;
    end else begin
      pr = PROD_W'(in_r) * PROD_W'(coef.cr);
      pg = PROD_W'(in_g) * PROD_W'(coef.cg);
      pb = PROD_W'(in_b) * PROD_W'(coef.cb);
    end
  end

  logic            s1_valid, s2_ready;
  logic [S1_W-1:0] s1_data;

  rgb_gray_stage #(.W(S1_W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready_c (in_ready),
    .in_data    ({pass, pr, pg, pb}),
    .out_valid  (s1_valid),
    .out_ready  (s2_ready),
    .out_data   (s1_data)
  );

  logic              s1_pass;
  logic [PROD_W-1:0] s1_pr, s1_pg, s1_pb;
  logic [SUM_W-1:0]  sum, sum_adj, shifted;
  logic [SUM_W-DATA_W-1:0] gray_hi;
  logic [DATA_W-1:0] gray;
  logic [S2_W-1:0]   s2_in;

  assign s1_pass = s1_data[S1_W-1];
  assign s1_pr   = s1_data[3*PROD_W-1 -: PROD_W];
  assign s1_pg   = s1_data[2*PROD_W-1 -: PROD_W];
  assign s1_pb   = s1_data[PROD_W-1 -: PROD_W];

  assign sum = SUM_W'(s1_pr) + SUM_W'(s1_pg) + SUM_W'(s1_pb);

`ifdef RGB_GRAY_ROUND_EN
  assign sum_adj = sum + (SUM_W'(1) << (COEF_W - 1));
`else
  assign sum_adj = sum;
`endif

  assign shifted = sum_adj >> COEF_W;
  assign gray_hi = shifted[SUM_W-1:DATA_W];

`ifdef RGB_GRAY_ROUND_EN
  assign gray = (|gray_hi) ? '1 : shifted[DATA_W-1:0];
`else
  assign gray = shifted[DATA_W-1:0];

  // Coefficients sum to 2^COEF_W, so the truncated result never exceeds DATA_W bits.
  a_gray_fits: assert property (@(posedge clk) disable iff (!rst_n)
    (s1_valid && !s1_pass) |-> (gray_hi == '0));
`endif

  assign s2_in = s1_pass ? {s1_pr[PROD_W-1:COEF_W], s1_pg[PROD_W-1:COEF_W], s1_pb[PROD_W-1:COEF_W]}
                         : {gray, gray, gray};

  logic [S2_W-1:0] s2_data;

  rgb_gray_stage #(.W(S2_W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s1_valid),
    .in_ready_c (s2_ready),
    .in_data    (s2_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (s2_data)
  );

  assign out_r = s2_data[3*DATA_W-1 -: DATA_W];
  assign out_g = s2_data[2*DATA_W-1 -: DATA_W];
  assign out_b = s2_data[DATA_W-1 -: DATA_W];

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Scoreboard bench for rgb_gray_stream: accepted beats push expected pixels,
// an independent output monitor pops and compares.
module tb_rgb_gray_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_r, out_g, out_b;

  rgb_gray_stream #(.DATA_W(8), .COEF_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   free_run = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: weighted sum from the published integer weights, divided by 256.
  function automatic logic [23:0] model(input logic [7:0] r, g, b, input logic [1:0] m);
    int w[3][3] = '{'{77, 150, 29}, '{54, 183, 19}, '{85, 86, 85}};
    int s, v;
    if (m == 2'd3) return {r, g, b};
    s = int'(r) * w[m][0] + int'(g) * w[m][1] + int'(b) * w[m][2];
`ifdef RGB_GRAY_ROUND_EN
    v = (s + 128) / 256;
    if (v > 255) v = 255;
`else
    v = s / 256;
`endif
    return {8'(v), 8'(v), 8'(v)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Input side: record every beat that will transfer on the coming edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      e.rgb = model(in_r, in_g, in_b, in_mode);
      e.cyc = cyc;
      sb.push_back(e);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Output side: pop on every transfer; also check stalled outputs stay put.
  logic        prev_stall = 1'b0;
  logic [23:0] prev_d = '0;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'({out_r, out_g, out_b}), 32'(prev_d));
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'({out_r, out_g, out_b}), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", 32'({out_r, out_g, out_b}), 32'(e.rgb));
        if (free_run) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    prev_stall <= rst_n && out_valid && !out_ready;
    prev_d     <= {out_r, out_g, out_b};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] r, g, b, input logic [1:0] m);
    bit done = 1'b0;
    int n = 0;
    in_r = r; in_g = g; in_b = b; in_mode = m; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL send_timeout in_ready stuck low for %0d cycles", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset with live inputs: nothing may come out.
    in_valid = 1'b1; in_r = 8'h55; in_g = 8'hAA; in_b = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rgb", 32'({out_r, out_g, out_b}), 32'd0);
    end
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    chk("no_spurious", 32'(out_valid), 32'd0);
    tick();

    // Directed per-mode pixels, free-running sink.
    free_run = 1'b1;
    send(8'd255, 8'd0,   8'd0,   2'd0);
    send(8'd255, 8'd255, 8'd255, 2'd0);
    send(8'd0,   8'd200, 8'd0,   2'd1);
    send(8'd90,  8'd90,  8'd90,  2'd2);
    send(8'd10,  8'd20,  8'd30,  2'd3);
    repeat (4) tick();
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_hold", 32'({out_r, out_g, out_b}), 32'h0A141E);
    tick();
    free_run = 1'b0;

    // Backpressure: six pixels against a stalled sink.
    begin
      int base;
      base = acc_cnt;
      out_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 6; i++)
            send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        end
        begin
          repeat (5) @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_accepted", 32'(acc_cnt - base), 32'd2);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          tick();
          out_ready = 1'b1;
          for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_out_valid", 32'(out_valid), 32'd1);
          end
        end
      join
    end
    drain();

    // Alternating BT.601/BT.709 per beat.
    free_run = 1'b1;
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 2'(i % 2));
    drain();
    free_run = 1'b0;

    // Random traffic with random sink stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two pixels in flight: both must be discarded.
    out_ready = 1'b0;
    send(8'd1, 8'd2, 8'd3, 2'd3);
    send(8'd4, 8'd5, 8'd6, 2'd0);
    tick();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_rgb", 32'({out_r, out_g, out_b}), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
